sseg_serial_driver: RTL and testbench
=====================================

Name: sseg_serial_driver

Overview:
Parametrised serial seven-segment driver. Captures a display frame of DIGITS digits, in either hex-text mode (4-bit code per digit, decoded internally) or raw graphic mode (8-bit segment pattern per digit). Shifts the frame out on a clock/data pair into the board's cascaded shift-register display chain, then enables the display. Adds to the previous driver: digit count and serial clock rate as parameters, per-digit blanking for flash, and a busy/done handshake.

Parameters:
- DIGITS, 8: number of digits in the chain; range 1..16.
- CLK_DIV, 2: clk cycles per seg_clk half-period; must be >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  frame request; sampled only in IDLE; held high gives back-to-back refresh
- text_mode  in  1  1 = hex-text mode, 0 = graphic mode
- flash  in  1  blink phase; 1 = blank every digit whose les bit is set
- hexs  in  4*DIGITS  hex codes; digit i = hexs[4i+3:4i]
- pattern  in  8*DIGITS  graphic bytes; digit i = pattern[8i+7:8i]
- point  in  DIGITS  decimal point per digit (1 = lit; text mode only)
- les  in  DIGITS  per-digit flash enable
- seg_clk  out  1  serial shift clock; receiver samples on rising edge
- seg_sout  out  1  serial data
- seg_pen  out  1  display enable (1 = shown)
- seg_clrn  out  1  chain clear, active low
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset values: seg_clk=0, seg_sout=1, seg_pen=0, seg_clrn=0, busy=0, done=0, state=IDLE.
- Reset is asynchronous. Asserting it mid-frame aborts the frame and forces the reset values immediately.
- seg_clrn goes to 1 on the first clk edge after rst deasserts and stays 1.
- States: IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
- IDLE:
  - seg_clk=0, busy=0.
  - If start=1 at a clk edge, go to LOAD.
- LOAD (1 cycle):
  - busy=1, seg_pen=0.
  - Capture all inputs into a shift register of 8*DIGITS bits.
  - Inputs are don't-care after LOAD; changes mid-frame do not affect the frame.
- Byte for digit i, segment order {dp,g,f,e,d,c,b,a}, active-low:
  - Text mode: ~{point[i], dec(hexs digit)}.
  - Graphic mode: pattern byte sent unmodified.
  - If flash=1 and les[i]=1: byte = 8'hFF (blank) in both modes.
- dec table (active-high gfedcba):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- SHIFT:
  - busy=1.
  - Order: digit DIGITS-1 first, MSB first within each byte; 8*DIGITS bits in total.
  - Each bit: seg_sout updated on entry to the low phase, seg_clk=0 for CLK_DIV cycles, then seg_clk=1 for CLK_DIV cycles.
  - seg_sout is stable across the rising edge.
  - Bit counter covers 0..8*DIGITS-1.
  - After the last high phase: seg_clk=0, go to DONE.
  - SHIFT lasts exactly 16*DIGITS*CLK_DIV cycles.
- DONE (1 cycle):
  - done=1, busy=0.
  - seg_pen=1; it stays 1 until the next LOAD.
  - seg_sout returns to 1.
  - Next state is IDLE.
- start asserted while busy or in DONE is ignored; no queuing.
- With start held high, the next LOAD follows after 1 IDLE cycle. Frame period = 16*DIGITS*CLK_DIV + 3 cycles.
- seg_pen=0 during LOAD/SHIFT, so partial shifting is never displayed.

Test Plan:
- Reset and bring-up: rst pulsed, DIGITS=8, CLK_DIV=2 -> all outputs at reset values, including while clk is stopped. seg_clrn=1 one edge after release. No seg_clk edges while start=0.
- Text frame: text_mode=1, hexs=32'h76543210, point=8'h01, les=0, start pulse -> busy=1 for 1+256 cycles, exactly 64 seg_clk rising edges. Bytes captured in order F8,82,92,99,B0,A4,F9,40. Then done for 1 cycle, seg_pen=1.
- Flash blanking: same frame with les=8'h81, flash=1 -> first and last bytes FF, the others unchanged. With flash=0 the bytes are identical to the text-frame case.
- Graphic mode: text_mode=0, pattern=64'h0123456789ABCDEF, point=8'hFF -> bytes 01,23,45,67,89,AB,CD,EF. point is ignored.
- Handshake: start held high for 3 frames -> done pulses 259 cycles apart. Changing hexs and toggling start mid-SHIFT alters neither the current frame nor its length.
- Parametrisation and abort: DIGITS=4, CLK_DIV=1 -> 32 seg_clk edges, each low/high phase 1 cycle, SHIFT = 64 cycles. rst asserted at bit 10 -> immediate reset values. The next start sends a complete, correct frame.

Source files
------------

// File: rtl/sseg_serial_driver_if.sv
// Bus bundle for the serial seven-segment driver: frame request/data in, serial pins and
// handshake out. The master modport is the frame source, the slave modport is the driver.
interface sseg_serial_driver_if #(
  parameter int unsigned DIGITS = 8
) ();
  logic                  start;
  logic                  text_mode;
  logic                  flash;
  logic [4*DIGITS-1:0]   hexs;
  logic [8*DIGITS-1:0]   pattern;
  logic [DIGITS-1:0]     point;
  logic [DIGITS-1:0]     les;
  logic                  seg_clk;
  logic                  seg_sout;
  logic                  seg_pen;
  logic                  seg_clrn;
  logic                  busy;
  logic                  done;

  modport master (
    output start, text_mode, flash, hexs, pattern, point, les,
    input  seg_clk, seg_sout, seg_pen, seg_clrn, busy, done
  );

  modport slave (
    input  start, text_mode, flash, hexs, pattern, point, les,
    output seg_clk, seg_sout, seg_pen, seg_clrn, busy, done
  );
endinterface

// File: rtl/sseg_serial_driver.sv
// Serial seven-segment driver: latches a frame of DIGITS bytes, shifts it MSB-first
// (last digit first) into the cascaded shift-register chain, then enables the display.
module sseg_serial_driver #(
  parameter int unsigned DIGITS  = 8,
  parameter int unsigned CLK_DIV = 2
) (
  input logic                 clk,
  input logic                 rst,
  sseg_serial_driver_if.slave bus
);
  localparam int unsigned NBITS = 8 * DIGITS;
  localparam int unsigned BIT_W = $clog2(NBITS);
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [NBITS-1:0] shreg_q;
  logic [NBITS-1:0] frame;
  logic [DIV_W-1:0] div_q;
  logic [BIT_W-1:0] bit_q;
  logic             phase_q;   // 0 = low half of seg_clk, 1 = high half
  logic             pen_q;
  logic             clrn_q;
  logic             div_last;
  logic             bit_last;
  logic             sclk, sout, busy, done;

  // Active-high gfedcba glyphs for hex digits.
  function automatic logic [6:0] dec(input logic [3:0] h);
    case (h)
      4'h0: dec = 7'h3F;  4'h1: dec = 7'h06;  4'h2: dec = 7'h5B;  4'h3: dec = 7'h4F;
      4'h4: dec = 7'h66;  4'h5: dec = 7'h6D;  4'h6: dec = 7'h7D;  4'h7: dec = 7'h07;
      4'h8: dec = 7'h7F;  4'h9: dec = 7'h6F;  4'hA: dec = 7'h77;  4'hB: dec = 7'h7C;
      4'hC: dec = 7'h39;  4'hD: dec = 7'h5E;  4'hE: dec = 7'h79;
      default: dec = 7'h71;
    endcase
  endfunction

  assign div_last = (div_q == DIV_W'(CLK_DIV - 1));
  assign bit_last = (bit_q == BIT_W'(NBITS - 1));

  // Build the active-low frame; digit i occupies frame[8i+7:8i], blanking wins over mode.
  always_comb begin
    frame = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bus.flash && bus.les[i]) begin
        frame[8*i +: 8] = 8'hFF;
      end else if (bus.text_mode) begin
        frame[8*i +: 8] = ~{bus.point[i], dec(bus.hexs[4*i +: 4])};
      end else begin
        frame[8*i +: 8] = bus.pattern[8*i +: 8];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.start) state_d = StLoad;
      StLoad:  state_d = StShift;
      StShift: if (phase_q && div_last && bit_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Frame capture and bit/phase timing; the shift happens as each high phase ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
    end else if (state_q == StLoad) begin
      shreg_q <= frame;
      div_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
    end else if (state_q == StShift) begin
      if (div_last) begin
        div_q   <= '0;
        phase_q <= ~phase_q;
        if (phase_q) begin
          bit_q   <= bit_q + 1'b1;
          shreg_q <= {shreg_q[NBITS-2:0], 1'b1};
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  // Display enable drops on entry to LOAD and rises on entry to DONE; clear releases once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pen_q  <= 1'b0;
      clrn_q <= 1'b0;
    end else begin
      clrn_q <= 1'b1;
      if (state_d == StLoad)      pen_q <= 1'b0;
      else if (state_d == StDone) pen_q <= 1'b1;
    end
  end

  // Output decode from registered state only, so pins are glitch-free.
  always_comb begin
    sclk = 1'b0;
    sout = 1'b1;
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      StLoad:  busy = 1'b1;
      StShift: begin
        busy = 1'b1;
        sclk = phase_q;
        sout = shreg_q[NBITS-1];
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  assign bus.seg_clk  = sclk;
  assign bus.seg_sout = sout;
  assign bus.seg_pen  = pen_q;
  assign bus.seg_clrn = clrn_q;
  assign bus.busy     = busy;
  assign bus.done     = done;
endmodule

// File: tb/tb_sseg_serial_driver.sv
// Bench for sseg_serial_driver: instance A (8 digits, div 2) and instance B (4 digits, div 1).
module tb_sseg_serial_driver;
  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  sseg_serial_driver_if #(.DIGITS(8)) bus_a ();
  sseg_serial_driver_if #(.DIGITS(4)) bus_b ();

  sseg_serial_driver #(.DIGITS(8), .CLK_DIV(2)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  sseg_serial_driver #(.DIGITS(4), .CLK_DIV(1)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Serial receiver models: capture seg_sout on every seg_clk rise.
  int          edges_a = 0, edges_b = 0, glitch_a = 0, glitch_b = 0;
  logic [63:0] bits_a = '0, bits_b = '0;
  logic        pclk_a = 1'b0, pclk_b = 1'b0, psout_a = 1'b1, psout_b = 1'b1;

  always @(posedge clk) begin
    #1;
    if (bus_a.seg_clk && !pclk_a) begin
      edges_a++;
      bits_a = {bits_a[62:0], bus_a.seg_sout};
      if (bus_a.seg_sout !== psout_a) glitch_a++;
    end
    pclk_a  = bus_a.seg_clk;
    psout_a = bus_a.seg_sout;
    if (bus_b.seg_clk && !pclk_b) begin
      edges_b++;
      bits_b = {bits_b[62:0], bus_b.seg_sout};
      if (bus_b.seg_sout !== psout_b) glitch_b++;
    end
    pclk_b  = bus_b.seg_clk;
    psout_b = bus_b.seg_sout;
  end

  bit   sel = 1'b0;
  logic cur_busy, cur_done, cur_clk, cur_sout, cur_pen;
  always_comb begin
    cur_busy = sel ? bus_b.busy     : bus_a.busy;
    cur_done = sel ? bus_b.done     : bus_a.done;
    cur_clk  = sel ? bus_b.seg_clk  : bus_a.seg_clk;
    cur_sout = sel ? bus_b.seg_sout : bus_a.seg_sout;
    cur_pen  = sel ? bus_b.seg_pen  : bus_a.seg_pen;
  end

  task automatic drive_start(input bit s, input logic v);
    if (s) bus_b.start = v;
    else   bus_a.start = v;
  endtask

  // One start pulse, then follow the frame to its done pulse and check everything about it.
  task automatic run_frame(input bit s, input logic [63:0] exp_bits, input int exp_edges,
                           input int exp_busy, input int div, input bit disturb,
                           input string name);
    int   e0, g0, busy_cnt, k, phase_err;
    bit   got;
    logic exp_clk;
    logic [63:0] got_bits;
    sel = s;
    @(negedge clk);
    e0 = s ? edges_b : edges_a;
    g0 = s ? glitch_b : glitch_a;
    drive_start(s, 1'b1);
    busy_cnt = 0; k = 0; phase_err = 0; got = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (cur_busy) begin
        busy_cnt++;
        if (busy_cnt > 1) begin
          exp_clk = ((k / div) % 2) == 1;
          if (cur_clk !== exp_clk) phase_err++;
          k++;
        end
      end
      if (cur_done) begin
        got = 1'b1;
        break;
      end
      if (disturb && c >= 100 && c < 110) begin
        drive_start(s, c[0]);
        if (s) begin
          bus_b.hexs = ~bus_b.hexs; bus_b.pattern = ~bus_b.pattern;
        end else begin
          bus_a.hexs = ~bus_a.hexs; bus_a.pattern = ~bus_a.pattern;
        end
      end else begin
        drive_start(s, 1'b0);
      end
    end
    drive_start(s, 1'b0);
    check({name, "_done_seen"}, 64'(got), 64'd1);
    check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
    check({name, "_clk_phase_errs"}, 64'(phase_err), 64'd0);
    check({name, "_pen_at_done"}, 64'(cur_pen), 64'd1);
    check({name, "_sout_idle"}, 64'(cur_sout), 64'd1);
    @(negedge clk);
    check({name, "_done_width"}, {62'd0, cur_done, cur_busy}, 64'd0);
    check({name, "_edges"}, 64'((s ? edges_b : edges_a) - e0), 64'(exp_edges));
    got_bits = s ? {32'd0, bits_b[31:0]} : bits_a;
    check({name, "_bits"}, got_bits, exp_bits);
    check({name, "_sout_glitch"}, 64'((s ? glitch_b : glitch_a) - g0), 64'd0);
  endtask

  typedef struct {
    logic        text_mode;
    logic        flash;
    logic [31:0] hexs;
    logic [63:0] pattern;
    logic [7:0]  point;
    logic [7:0]  les;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic apply_a(input vec_t v);
    bus_a.text_mode = v.text_mode;
    bus_a.flash     = v.flash;
    bus_a.hexs      = v.hexs;
    bus_a.pattern   = v.pattern;
    bus_a.point     = v.point;
    bus_a.les       = v.les;
  endtask

  initial begin
    int e0, dcount;
    int dt[3];
    bit reached;

    vecs[0] = '{1'b1, 1'b0, 32'h76543210, 64'h0, 8'h01, 8'h00, 64'hF8829299B0A4F940};
    vecs[1] = '{1'b1, 1'b1, 32'h76543210, 64'h0, 8'h01, 8'h81, 64'hFF829299B0A4F9FF};
    vecs[2] = '{1'b1, 1'b0, 32'h76543210, 64'h0, 8'h01, 8'h81, 64'hF8829299B0A4F940};
    vecs[3] = '{1'b0, 1'b0, 32'h0, 64'h0123456789ABCDEF, 8'hFF, 8'h00, 64'h0123456789ABCDEF};
    vecs[4] = '{1'b0, 1'b1, 32'h0, 64'h0123456789ABCDEF, 8'hFF, 8'h0F, 64'h01234567FFFFFFFF};
    vecs[5] = '{1'b1, 1'b0, 32'hFEDCBA98, 64'h0, 8'h80, 8'h00, 64'h0E86A1C683889080};

    bus_a.start = 1'b0; bus_b.start = 1'b0;
    apply_a(vecs[0]);
    bus_b.text_mode = 1'b1; bus_b.flash = 1'b0; bus_b.hexs = 16'h3210;
    bus_b.pattern = '0; bus_b.point = 4'h1; bus_b.les = 4'h0;

    // Reset values with the clock stopped, then with it running.
    #12;
    check("rst_nocl_a", {58'd0, bus_a.seg_clk, bus_a.seg_sout, bus_a.seg_pen, bus_a.seg_clrn,
                         bus_a.busy, bus_a.done}, 64'b010000);
    check("rst_nocl_b", {58'd0, bus_b.seg_clk, bus_b.seg_sout, bus_b.seg_pen, bus_b.seg_clrn,
                         bus_b.busy, bus_b.done}, 64'b010000);
    clk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_clk_a", {58'd0, bus_a.seg_clk, bus_a.seg_sout, bus_a.seg_pen, bus_a.seg_clrn,
                        bus_a.busy, bus_a.done}, 64'b010000);
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    check("clrn_before_edge", 64'(bus_a.seg_clrn), 64'd0);
    @(negedge clk);
    check("clrn_after_edge_a", 64'(bus_a.seg_clrn), 64'd1);
    check("clrn_after_edge_b", 64'(bus_b.seg_clrn), 64'd1);
    e0 = edges_a;
    repeat (20) @(negedge clk);
    check("idle_no_edges", 64'(edges_a - e0), 64'd0);
    check("idle_not_busy", 64'(bus_a.busy), 64'd0);

    // Table-driven frames on instance A.
    for (int i = 0; i < 6; i++) begin
      apply_a(vecs[i]);
      run_frame(1'b0, vecs[i].exp, 64, 257, 2, 1'b0, $sformatf("vec%0d", i));
    end

    // Mid-SHIFT input changes and start toggles must not touch the frame.
    apply_a(vecs[0]);
    run_frame(1'b0, vecs[0].exp, 64, 257, 2, 1'b1, "disturb");

    // start held high: back-to-back frames.
    sel = 1'b0;
    @(negedge clk);
    e0 = edges_a;
    bus_a.start = 1'b1;
    dcount = 0;
    for (int c = 0; c < 2000 && dcount < 3; c++) begin
      @(negedge clk);
      if (bus_a.done) begin
        dt[dcount] = c;
        dcount++;
        if (dcount == 3) bus_a.start = 1'b0;
      end
    end
    bus_a.start = 1'b0;
    check("b2b_count", 64'(dcount), 64'd3);
    if (dcount == 3) begin
      check("b2b_gap1", 64'(dt[1] - dt[0]), 64'd259);
      check("b2b_gap2", 64'(dt[2] - dt[1]), 64'd259);
    end
    repeat (4) @(negedge clk);
    check("b2b_no_queue", 64'(bus_a.busy), 64'd0);
    check("b2b_edges", 64'(edges_a - e0), 64'd192);
    check("b2b_pen_held", 64'(bus_a.seg_pen), 64'd1);

    // Instance B: 4 digits, one-cycle phases.
    run_frame(1'b1, 64'hB0A4F940, 32, 65, 1, 1'b0, "b_text");

    // Abort at bit 10.
    sel = 1'b1;
    @(negedge clk);
    e0 = edges_b;
    bus_b.start = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (edges_b - e0 >= 10) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("abort_reached_bit10", 64'(reached), 64'd1);
    rst_b = 1'b1;
    #1;
    check("abort_outputs", {58'd0, bus_b.seg_clk, bus_b.seg_sout, bus_b.seg_pen, bus_b.seg_clrn,
                            bus_b.busy, bus_b.done}, 64'b010000);
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    check("abort_clrn_back", 64'(bus_b.seg_clrn), 64'd1);
    check("abort_stays_idle", 64'(bus_b.busy), 64'd0);
    bus_b.hexs = 16'hA5C9;
    bus_b.point = 4'h0;
    run_frame(1'b1, 64'h8892C690, 32, 65, 1, 1'b0, "b_after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
